// File: rtl/ps2_kbd_pkg.sv
// Shared scancode constants and decoder state type for the PS/2 keyboard path.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_PROC,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 scancode to ASCII translation.
module ps2_keymap (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       alpha;

  // Letters carry only their lowercase glyph; the uppercase form is derived below.
  always_comb begin
    lo = '0;
    hi = '0;
    case (code)
      8'h1C: lo = "a";
      8'h32: lo = "b";
      8'h21: lo = "c";
      8'h23: lo = "d";
      8'h24: lo = "e";
      8'h2B: lo = "f";
      8'h34: lo = "g";
      8'h33: lo = "h";
      8'h43: lo = "i";
      8'h3B: lo = "j";
      8'h42: lo = "k";
      8'h4B: lo = "l";
      8'h3A: lo = "m";
      8'h31: lo = "n";
      8'h44: lo = "o";
      8'h4D: lo = "p";
      8'h15: lo = "q";
      8'h2D: lo = "r";
      8'h1B: lo = "s";
      8'h2C: lo = "t";
      8'h3C: lo = "u";
      8'h2A: lo = "v";
      8'h1D: lo = "w";
      8'h22: lo = "x";
      8'h35: lo = "y";
      8'h1A: lo = "z";
      8'h16: begin lo = "1";   hi = "!";   end
      8'h1E: begin lo = "2";   hi = "@";   end
      8'h26: begin lo = "3";   hi = "#";   end
      8'h25: begin lo = "4";   hi = "$";   end
      8'h2E: begin lo = "5";   hi = "%";   end
      8'h36: begin lo = "6";   hi = "^";   end
      8'h3D: begin lo = "7";   hi = "&";   end
      8'h3E: begin lo = "8";   hi = "*";   end
      8'h46: begin lo = "9";   hi = "(";   end
      8'h45: begin lo = "0";   hi = ")";   end
      8'h0E: begin lo = 8'h60; hi = "~";   end
      8'h4E: begin lo = "-";   hi = "_";   end
      8'h55: begin lo = "=";   hi = "+";   end
      8'h54: begin lo = "[";   hi = "{";   end
      8'h5B: begin lo = "]";   hi = "}";   end
      8'h5D: begin lo = 8'h5C; hi = "|";   end
      8'h4C: begin lo = ";";   hi = ":";   end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ",";   hi = "<";   end
      8'h49: begin lo = ".";   hi = ">";   end
      8'h4A: begin lo = "/";   hi = "?";   end
      8'h29: lo = 8'h20;
      8'h5A: lo = 8'h0D;
      8'h66: lo = 8'h08;
      8'h0D: lo = 8'h09;
      8'h76: lo = 8'h1B;
      default: begin
        lo = '0;
        hi = '0;
      end
    endcase
  end

  assign alpha = (lo >= 8'h61) && (lo <= 8'h7A);

  always_comb begin
    if (alpha) begin
      ascii = (shift ^ caps) ? (lo - 8'h20) : lo;
    end else if (shift && (hi != '0)) begin
      ascii = hi;
    end else begin
      ascii = lo;
    end
  end

endmodule

// File: rtl/ps2_keydec.sv
// Pops scancodes from the PS/2 receiver FIFO, tracks prefixes and modifiers,
// and presents each key make as a single-entry event with valid/ack handshake.
module ps2_keydec
  import ps2_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       ps2_rdn,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       caps_lock
);

  state_e     state_q;
  logic [7:0] byte_q;
  logic       ext_q, brk_q, shl_q, shr_q, caps_held_q;
  logic       rdn_q, valid_q, key_ext_q, caps_q;
  logic [7:0] code_q, ascii_q;
  logic [7:0] map_ascii;
  logic [7:0] ev_ascii;
  logic       is_shift;

  ps2_keymap u_keymap (
    .code  (byte_q),
    .shift (shl_q | shr_q),
    .caps  (caps_q),
    .ascii (map_ascii)
  );

  assign ev_ascii = ext_q ? '0 : map_ascii;
  assign is_shift = (byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_held_q <= 1'b0;
      rdn_q       <= 1'b1;
      valid_q     <= 1'b0;
      key_ext_q   <= 1'b0;
      caps_q      <= 1'b0;
      code_q      <= '0;
      ascii_q     <= '0;
    end else begin
      // Ack clears first; an event load later in this block overrides it.
      if (valid_q && key_ack) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (ps2_ready) begin
            byte_q  <= ps2_data;
            rdn_q   <= 1'b0;
            state_q <= ST_POP;
          end
        end
        ST_POP: begin
          rdn_q   <= 1'b1;
          state_q <= ST_PROC;
        end
        ST_PROC: begin
          state_q <= ST_IDLE;
          if (byte_q == SC_EXT) begin
            ext_q <= 1'b1;
          end else if (byte_q == SC_BRK) begin
            brk_q <= 1'b1;
          end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (ext_q && is_shift) begin
              // Fake shifts from extended keys leave modifier state untouched.
            end else if (brk_q) begin
              if (!ext_q) begin
                if (byte_q == SC_LSHIFT) shl_q       <= 1'b0;
                if (byte_q == SC_RSHIFT) shr_q       <= 1'b0;
                if (byte_q == SC_CAPS)   caps_held_q <= 1'b0;
              end
            end else if (byte_q == SC_LSHIFT) begin
              shl_q <= 1'b1;
            end else if (byte_q == SC_RSHIFT) begin
              shr_q <= 1'b1;
            end else if (byte_q == SC_CAPS) begin
              if (!caps_held_q) caps_q <= ~caps_q;
              caps_held_q <= 1'b1;
            end else if (!valid_q || key_ack) begin
              valid_q   <= 1'b1;
              code_q    <= byte_q;
              key_ext_q <= ext_q;
              ascii_q   <= ev_ascii;
            end else begin
              // ext_q must survive the stall so the deferred load reports it.
              ext_q   <= ext_q;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (key_ack) begin
            valid_q   <= 1'b1;
            code_q    <= byte_q;
            key_ext_q <= ext_q;
            ascii_q   <= ev_ascii;
            ext_q     <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ps2_rdn   = rdn_q;
  assign key_code  = code_q;
  assign key_ext   = key_ext_q;
  assign key_ascii = ascii_q;
  assign key_valid = valid_q;
  assign caps_lock = caps_q;

endmodule

// File: tb/tb_ps2_keydec.sv
// Bench for ps2_keydec: FIFO stand-in, behavioural decoder model, directed and random stimulus.
module tb_ps2_keydec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_rdn;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       caps_lock;

  always #5 clk = ~clk;

  ps2_keydec dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_data  (ps2_data),
    .ps2_ready (ps2_ready),
    .ps2_rdn   (ps2_rdn),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_ascii (key_ascii),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .caps_lock (caps_lock)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo[$];
  int pops_seen = 0;
  int pops_done = 0;
  bit chk_en = 1'b0;

  // Reference keyboard behaviour
  localparam logic [7:0] LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] SYM_CODES [20] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
    8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  localparam logic [7:0] SYM_LO [20] = '{
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
    8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  localparam logic [7:0] SYM_HI [20] = '{
    8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
    8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  function automatic logic [7:0] model_map(input logic [7:0] c, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (LETTER_CODES[i] == c) return (sh ^ cp) ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 20; i++)
      if (SYM_CODES[i] == c) return sh ? SYM_HI[i] : SYM_LO[i];
    case (c)
      8'h0E:   return sh ? 8'h7E : 8'h60;
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h0D:   return 8'h09;
      8'h76:   return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  bit m_rdn = 1'b1, m_valid = 1'b0, m_ext = 1'b0, m_caps = 1'b0;
  bit m_e = 1'b0, m_b = 1'b0, m_shl = 1'b0, m_shr = 1'b0, m_held = 1'b0, m_stalled = 1'b0;
  logic [7:0] m_code = 8'h00, m_ascii = 8'h00, m_byte = 8'h00;
  logic [7:0] p_code = 8'h00, p_ascii = 8'h00;
  bit p_ext = 1'b0;
  int m_delay = 0;

  // Applies one byte to the keyboard state; returns 1 when it yields a key event.
  function automatic bit decode(input logic [7:0] b);
    bit e, k;
    if (b == 8'hE0) begin m_e = 1'b1; return 1'b0; end
    if (b == 8'hF0) begin m_b = 1'b1; return 1'b0; end
    e = m_e; k = m_b; m_e = 1'b0; m_b = 1'b0;
    if (e && (b == 8'h12 || b == 8'h59)) return 1'b0;
    if (k) begin
      if (!e) begin
        if (b == 8'h12) m_shl = 1'b0;
        if (b == 8'h59) m_shr = 1'b0;
        if (b == 8'h58) m_held = 1'b0;
      end
      return 1'b0;
    end
    if (b == 8'h12) begin m_shl = 1'b1; return 1'b0; end
    if (b == 8'h59) begin m_shr = 1'b1; return 1'b0; end
    if (b == 8'h58) begin
      if (!m_held) m_caps = !m_caps;
      m_held = 1'b1;
      return 1'b0;
    end
    p_code  = b;
    p_ext   = e;
    p_ascii = e ? 8'h00 : model_map(b, m_shl | m_shr, m_caps);
    return 1'b1;
  endfunction

  // Timing: a byte taken at one edge takes effect two edges later; full events stall until ack.
  always @(posedge clk) begin
    bit ackclr;
    bit loaded;
    if (ps2_rdn === 1'b0) pops_seen++;
    if (reset) begin
      m_rdn = 1'b1; m_valid = 1'b0; m_ext = 1'b0; m_caps = 1'b0;
      m_e = 1'b0; m_b = 1'b0; m_shl = 1'b0; m_shr = 1'b0; m_held = 1'b0;
      m_stalled = 1'b0; m_code = 8'h00; m_ascii = 8'h00; m_delay = 0;
    end else begin
      ackclr = m_valid && key_ack;
      loaded = 1'b0;
      if (m_stalled) begin
        if (key_ack) begin
          m_valid = 1'b1; m_code = p_code; m_ext = p_ext; m_ascii = p_ascii;
          loaded = 1'b1; m_stalled = 1'b0;
        end
      end else if (m_delay > 0) begin
        m_delay--;
        m_rdn = 1'b1;
        if (m_delay == 0 && decode(m_byte)) begin
          if (!m_valid || key_ack) begin
            m_valid = 1'b1; m_code = p_code; m_ext = p_ext; m_ascii = p_ascii;
            loaded = 1'b1;
          end else begin
            m_stalled = 1'b1;
          end
        end
      end else if (ps2_ready) begin
        m_byte = ps2_data;
        m_rdn = 1'b0;
        m_delay = 2;
      end
      if (ackclr && !loaded) m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    ps2_ready = (fifo.size() != 0);
    ps2_data  = ps2_ready ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  // One clock: compare the DUT against the model, retire popped bytes, present the FIFO head.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("rdn",   8'(ps2_rdn),   8'(m_rdn));
      chk("valid", 8'(key_valid), 8'(m_valid));
      chk("code",  key_code,      m_code);
      chk("ext",   8'(key_ext),   8'(m_ext));
      chk("ascii", key_ascii,     m_ascii);
      chk("caps",  8'(caps_lock), 8'(m_caps));
      if (ps2_rdn === 1'b0) chk("rdn_needs_ready", 8'(ps2_ready), 8'd1);
    end
    while (pops_done < pops_seen) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pops_done++;
    end
    refresh();
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (fifo.size() != 0 && n < 200) begin tick(); n++; end
    chk("settle_fifo_empty", 8'(fifo.size()), 8'd0);
    repeat (4) tick();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 15))
      0: return 8'hE0;   1: return 8'hF0;   2: return 8'h12;   3: return 8'h59;
      4: return 8'h58;   5: return 8'h1C;   6: return 8'h16;   7: return 8'h4E;
      8: return 8'h52;   9: return 8'h29;  10: return 8'h0E;  11: return 8'h75;
      12: return 8'h32; 13: return 8'h5A;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int p0;

    chk("pin_a",      model_map(8'h1C, 1'b0, 1'b0), 8'h61);
    chk("pin_A",      model_map(8'h1C, 1'b1, 1'b0), 8'h41);
    chk("pin_a_sc",   model_map(8'h1C, 1'b1, 1'b1), 8'h61);
    chk("pin_1_caps", model_map(8'h16, 1'b0, 1'b1), 8'h31);
    chk("pin_bang",   model_map(8'h16, 1'b1, 1'b0), 8'h21);
    chk("pin_under",  model_map(8'h4E, 1'b1, 1'b0), 8'h5F);
    chk("pin_quote",  model_map(8'h52, 1'b0, 1'b0), 8'h27);
    chk("pin_dquote", model_map(8'h52, 1'b1, 1'b0), 8'h22);
    chk("pin_enter",  model_map(8'h5A, 1'b1, 1'b0), 8'h0D);
    chk("pin_unmap",  model_map(8'h07, 1'b0, 1'b0), 8'h00);

    repeat (3) tick();
    chk("rst_rdn",   8'(ps2_rdn),   8'd1);
    chk("rst_valid", 8'(key_valid), 8'd0);
    chk("rst_code",  key_code,      8'h00);
    chk("rst_ascii", key_ascii,     8'h00);
    chk("rst_caps",  8'(caps_lock), 8'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single make: latency and pop count
    p0 = pops_seen;
    push(8'h1C);
    n = 0;
    while (key_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("latency_edges", 8'(n), 8'd3);
    settle();
    chk("single_pops", 8'(pops_seen - p0), 8'd1);
    chk("a_code",  key_code,  8'h1C);
    chk("a_ascii", key_ascii, 8'h61);
    chk("a_ext",   8'(key_ext), 8'd0);
    ack_pulse();
    push(8'hF0); push(8'h1C);
    settle();
    chk("break_no_event", 8'(key_valid), 8'd0);

    // Shifted keys
    push(8'h12); push(8'h16);
    settle();
    chk("shift_bang", key_ascii, 8'h21);
    ack_pulse();
    push(8'hF0); push(8'h12); push(8'h16);
    settle();
    chk("unshift_1", key_ascii, 8'h31);
    ack_pulse();

    // Caps lock with typematic repeat
    push(8'h58); push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
    settle();
    chk("caps_on", 8'(caps_lock), 8'd1);
    chk("caps_A",  key_ascii, 8'h41);
    ack_pulse();
    push(8'h12); push(8'h1C);
    settle();
    chk("caps_shift_a", key_ascii, 8'h61);
    ack_pulse();
    push(8'hF0); push(8'h12);
    settle();

    // Extended keys
    push(8'hE0); push(8'h75);
    settle();
    chk("ext_code",  key_code,  8'h75);
    chk("ext_flag",  8'(key_ext), 8'd1);
    chk("ext_ascii", key_ascii, 8'h00);
    ack_pulse();
    push(8'hE0); push(8'h12); push(8'h1C);
    settle();
    chk("fake_shift_code",  key_code,  8'h1C);
    chk("fake_shift_ascii", key_ascii, 8'h41);
    chk("fake_shift_ext",   8'(key_ext), 8'd0);
    ack_pulse();

    // Backpressure
    p0 = pops_seen;
    push(8'h1C); push(8'h32); push(8'h16);
    repeat (15) tick();
    chk("bp_pops",  8'(pops_seen - p0), 8'd2);
    chk("bp_ready", 8'(ps2_ready), 8'd1);
    chk("bp_code",  key_code, 8'h1C);
    ack_pulse();
    chk("bp_load_code",  key_code, 8'h32);
    chk("bp_load_valid", 8'(key_valid), 8'd1);
    repeat (8) tick();
    ack_pulse();
    chk("bp_third_code", key_code, 8'h16);
    ack_pulse();
    chk("bp_drained", 8'(key_valid), 8'd0);
    settle();

    // Reset during POP
    push(8'h1C);
    n = 0;
    while (ps2_rdn !== 1'b0 && n < 10) begin tick(); n++; end
    chk("pop_observed", 8'(ps2_rdn), 8'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rp_rdn",   8'(ps2_rdn),   8'd1);
    chk("rp_valid", 8'(key_valid), 8'd0);
    chk("rp_code",  key_code,      8'h00);
    chk("rp_ext",   8'(key_ext),   8'd0);
    chk("rp_ascii", key_ascii,     8'h00);
    chk("rp_caps",  8'(caps_lock), 8'd0);
    push(8'h1C);
    settle();
    chk("rp_after_code",  key_code,  8'h1C);
    chk("rp_after_ascii", key_ascii, 8'h61);
    ack_pulse();

    // Random traffic
    repeat (3000) begin
      tick();
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) push(pick());
      key_ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    key_ack = 1'b1;
    repeat (40) tick();
    key_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
